square_lut_arbiter: RTL and testbench

Round-robin arbiter that shares a single `square_lut_4_bit` instance among `NUM_REQ` independent requesters. Each requester presents a signed 4-bit operand on a valid/ready channel. The arbiter grants one requester per cycle, squares the operand through the shared LUT, and returns the 8-bit result tagged with the requester index through a one-entry registered response slot. It sits between multiple datapath lanes and the single square LUT, replacing one LUT per lane.

---
 rtl/square_lut_arbiter_pkg.sv | 15 +
 rtl/square_lut_4_bit.sv | 32 +++
 rtl/square_lut_arbiter_picker.sv | 37 +++
 rtl/square_lut_arbiter.sv | 126 ++++++++++++
 tb/tb_square_lut_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/square_lut_arbiter_pkg.sv
// Shared constants and types for the square LUT arbiter.
// Holds operand/result widths, slot state encoding and statistics counter width.
// No ports; imported by the arbiter top and its sub-modules.
package square_lut_arbiter_pkg;

  localparam int SQ_IN_WIDTH  = 4;
  localparam int SQ_OUT_WIDTH = 8;
  localparam int STAT_WIDTH   = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/square_lut_4_bit.sv
// Square of a signed 4-bit operand by table lookup.
// Latency: combinational. Backpressure: none.
// Ports: operand_i (signed -8..7), square_o (0..64, bit 7 always 0).
module square_lut_4_bit (
  input  logic [3:0] operand_i,
  output logic [7:0] square_o
);

  always_comb begin
    square_o = 8'd0;
    case (operand_i)
      4'h0: square_o = 8'd0;
      4'h1: square_o = 8'd1;
      4'h2: square_o = 8'd4;
      4'h3: square_o = 8'd9;
      4'h4: square_o = 8'd16;
      4'h5: square_o = 8'd25;
      4'h6: square_o = 8'd36;
      4'h7: square_o = 8'd49;
      4'h8: square_o = 8'd64;  // -8
      4'h9: square_o = 8'd49;  // -7
      4'hA: square_o = 8'd36;
      4'hB: square_o = 8'd25;
      4'hC: square_o = 8'd16;
      4'hD: square_o = 8'd9;
      4'hE: square_o = 8'd4;
      4'hF: square_o = 8'd1;   // -1
      default: square_o = 8'd0;
    endcase
  end

endmodule

// File: rtl/square_lut_arbiter_picker.sv
// rr_priority_picker: first set request at or after start_i, wrapping modulo NUM_REQ.
// Latency: combinational. Backpressure: none; caller gates the grant.
// Ports: req_i (request vector), start_i (search start), grant_oh_o (one-hot or zero), grant_idx_o.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  int              sum;
  logic [IDX_W-1:0] pos;
  logic            found;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = 0;
    pos         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap by subtraction so non-power-of-two NUM_REQ works.
      sum = int'(start_i) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pos = sum[IDX_W-1:0];
      if (!found && req_i[pos]) begin
        found          = 1'b1;
        grant_oh_o[pos] = 1'b1;
        grant_idx_o    = pos;
      end
    end
  end

endmodule

// File: rtl/square_lut_arbiter.sv
// Round-robin arbiter sharing one square LUT among NUM_REQ requesters; result lands in a one-entry slot.
// Latency: accept in cycle N gives rsp_valid from cycle N+1; one result per cycle with rsp_ready high.
// Backpressure: slot full with rsp_ready low holds rsp_* stable and drives all req_ready low.
// Ports: clk, rst (async active-high), req_valid/req_ready/req_data (4 bits per requester),
//        rsp_valid/rsp_ready/rsp_data/rsp_id, grant_count (only with SQUARE_ARB_STATS_EN).
module square_lut_arbiter
  import square_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*SQ_IN_WIDTH-1:0]  req_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [SQ_OUT_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]             rsp_id
`ifdef SQUARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0]   grant_count
`endif
);

  slot_state_e             state_q, state_d;
  logic [SQ_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     start_idx;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [SQ_IN_WIDTH-1:0]  operand;
  logic [SQ_OUT_WIDTH-1:0] square;
  logic                    slot_free;
  logic                    accept;

  assign start_idx = (last_grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_WIDTH)
  ) u_picker (
    .req_i       (req_valid),
    .start_i     (start_idx),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

  always_comb begin
    operand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == ID_WIDTH'(k)) operand = req_data[k*SQ_IN_WIDTH +: SQ_IN_WIDTH];
    end
  end

  square_lut_4_bit u_lut (
    .operand_i (operand),
    .square_o  (square)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SLOT_EMPTY;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready) state_d = accept ? SLOT_FULL : SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      rsp_data_d   = square;
      rsp_id_d     = pick_idx;
      last_grant_d = pick_idx;
    end
  end

  // Outputs; grant suppressed during reset so nothing is accepted then discarded.
  always_comb begin
    rsp_valid = (state_q == SLOT_FULL);
    slot_free = !rsp_valid || rsp_ready;
    req_ready = (slot_free && !rst) ? pick_oh : '0;
    accept    = |(req_valid & req_ready);
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

`ifdef SQUARE_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[k] && req_ready[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_count[k*STAT_WIDTH +: STAT_WIDTH] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_square_lut_arbiter.sv
module tb_square_lut_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
`ifdef SQUARE_ARB_STATS_EN
  logic [63:0] grant_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  square_lut_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef SQUARE_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [3:0] v, logic [15:0] d, logic r,
                              logic [3:0] er, logic ev, logic [7:0] ed, logic [1:0] ei);
    vec_t t;
    t.valid = v; t.data = d; t.rdy = r;
    t.exp_ready = er; t.exp_vld = ev; t.exp_data = ed; t.exp_id = ei;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int v;
  int p;

  initial begin
    // Requester operands: r0=1, r1=-2, r2=3, r3=-4
    // All requesting from reset: grants 0,1,2,3,0,1
    add(4'b1111, 16'hC3E1, 1'b1, 4'b0001, 1'b0, 8'd0,  2'd0);
    add(4'b1111, 16'hC3E1, 1'b1, 4'b0010, 1'b1, 8'd1,  2'd0);
    add(4'b1111, 16'hC3E1, 1'b1, 4'b0100, 1'b1, 8'd4,  2'd1);
    add(4'b1111, 16'hC3E1, 1'b1, 4'b1000, 1'b1, 8'd9,  2'd2);
    add(4'b1111, 16'hC3E1, 1'b1, 4'b0001, 1'b1, 8'd16, 2'd3);
    add(4'b1111, 16'hC3E1, 1'b1, 4'b0010, 1'b1, 8'd1,  2'd0);
    add(4'b0000, 16'hC3E1, 1'b1, 4'b0000, 1'b1, 8'd4,  2'd1);
    // Sparse: only 1 and 3, last grant 1 -> 3,1,3
    add(4'b1010, 16'hC3E1, 1'b1, 4'b1000, 1'b0, 8'd0,  2'd0);
    add(4'b1010, 16'hC3E1, 1'b1, 4'b0010, 1'b1, 8'd16, 2'd3);
    add(4'b1010, 16'hC3E1, 1'b1, 4'b1000, 1'b1, 8'd4,  2'd1);
    add(4'b0000, 16'hC3E1, 1'b1, 4'b0000, 1'b1, 8'd16, 2'd3);
    // Requester 2 sweeps -8..7, one accept per cycle
    for (int j = 0; j < 16; j++) begin
      v = j - 8;
      p = j - 9;
      add(4'b0100, 16'((v & 15) << 8), 1'b1, 4'b0100, (j != 0), 8'(p * p), 2'd2);
    end
    add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'd49, 2'd2);
    // Backpressure: -3 from requester 1 held for 5 cycles, then drain + grant same cycle
    add(4'b0010, 16'h00D0, 1'b1, 4'b0010, 1'b0, 8'd0,  2'd0);
    for (int j = 0; j < 5; j++)
      add(4'b0110, 16'h05D0, 1'b0, 4'b0000, 1'b1, 8'd9, 2'd1);
    add(4'b0110, 16'h05D0, 1'b1, 4'b0100, 1'b1, 8'd9,  2'd1);
    add(4'b0000, 16'h05D0, 1'b1, 4'b0000, 1'b1, 8'd25, 2'd2);
    add(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'd0,  2'd0);

    // Reset state, with all requesters asking
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 16'hC3E1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 4'b0000);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, 8'd0);
    check("reset_rsp_id", rsp_id, 2'd0);
    rst = 1'b0;
    req_valid = 4'b0000;

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      rsp_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d_req_ready", i), req_ready, vecs[i].exp_ready);
      check($sformatf("row%0d_rsp_valid", i), rsp_valid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) begin
        check($sformatf("row%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
        check($sformatf("row%0d_rsp_id", i), rsp_id, vecs[i].exp_id);
      end
    end

    // Reset with a pending response: discarded, first grant goes to 0
    @(negedge clk);
    req_valid = 4'b1000;
    req_data  = 16'h3002;
    rsp_ready = 1'b0;
    #1;
    check("midrst_pre_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("midrst_full_vld", rsp_valid, 1'b1);
    check("midrst_full_data", rsp_data, 8'd9);
    check("midrst_full_id", rsp_id, 2'd3);
    rst = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("midrst_vld", rsp_valid, 1'b0);
    check("midrst_data", rsp_data, 8'd0);
    check("midrst_id", rsp_id, 2'd0);
    check("midrst_ready", req_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    check("postrst_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("postrst_vld", rsp_valid, 1'b1);
    check("postrst_id", rsp_id, 2'd0);
    check("postrst_data", rsp_data, 8'd4);

`ifdef SQUARE_ARB_STATS_EN
    // Saturation of requester 0's counter
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stats_reset", grant_count, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("stats_100", grant_count[15:0], 16'd100);
    repeat (69900) @(negedge clk);
    #1;
    check("stats_sat", grant_count[15:0], 16'hFFFF);
    check("stats_others", grant_count[63:16], 48'd0);
    req_valid = 4'b0000;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
